// File: rtl/bru_exec_pkg.sv
// Shared types for the branch execution unit: op encodings, EX-stage bundle, age compare.
// No logic of its own; latency n/a.
// No flow control; types only.
package bru_exec_pkg;

  localparam int BRU_PRF_W = 6;
  localparam int BRU_TAG_W = 6;
  localparam int BRU_CDB_N = 5;
  localparam int BRU_XLEN  = 32;

  typedef enum logic [3:0] {
    BRU_BEQ  = 4'd0,
    BRU_BNE  = 4'd1,
    BRU_BLT  = 4'd2,
    BRU_BGE  = 4'd3,
    BRU_BLTU = 4'd4,
    BRU_BGEU = 4'd5,
    BRU_JIRL = 4'd8
  } bru_op_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SHADOW = 1'b1
  } bru_state_e;

  // Everything EX needs, captured at the RR->EX edge.
  typedef struct packed {
    logic                 valid;
    logic [BRU_TAG_W-1:0] tag;
    logic [3:0]           op;          // raw Conf, may hold illegal codes
    logic [BRU_XLEN-1:0]  src1;        // rj
    logic [BRU_XLEN-1:0]  src2;        // rd
    logic [BRU_XLEN-1:0]  pc;
    logic [BRU_XLEN-1:0]  offs;
    logic                 pred_taken;
    logic [BRU_XLEN-1:0]  pred_target;
    logic [BRU_XLEN-1:0]  jirl_pred;
    logic [BRU_XLEN-1:0]  imm;
  } bru_ex_t;

  // True when tag a is strictly older than tag b, ages measured from the ROB head.
  function automatic logic age_older(input logic [BRU_TAG_W-1:0] a,
                                     input logic [BRU_TAG_W-1:0] b,
                                     input logic [BRU_TAG_W-1:0] base);
    logic [BRU_TAG_W-1:0] age_a;
    logic [BRU_TAG_W-1:0] age_b;
    age_a = a - base;
    age_b = b - base;
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/bru_exec_if.sv
// Issue-side awake bus into the branch unit and resolution bus out to the ROB.
// Wiring only; latency n/a.
// No backpressure: the issue side may present one uop every cycle.
interface bru_exec_if;
  import bru_exec_pkg::*;

  logic                 ready_awake;
  logic [BRU_PRF_W-1:0] Pj_awake;
  logic [BRU_PRF_W-1:0] Pd_old_awake;
  logic [3:0]           Conf_awake;
  logic [BRU_TAG_W-1:0] tag_rob_awake;
  logic [BRU_XLEN-1:0]  target_predict_awake;
  logic [BRU_XLEN-1:0]  imm_awake;

  logic                 res_valid;
  logic [BRU_TAG_W-1:0] res_tag;
  logic                 res_taken;
  logic [BRU_XLEN-1:0]  res_target;
  logic                 res_mispredict;

  // Issue queue / ROB side
  modport master (
    output ready_awake, Pj_awake, Pd_old_awake, Conf_awake, tag_rob_awake,
           target_predict_awake, imm_awake,
    input  res_valid, res_tag, res_taken, res_target, res_mispredict
  );

  // Branch unit side
  modport slave (
    input  ready_awake, Pj_awake, Pd_old_awake, Conf_awake, tag_rob_awake,
           target_predict_awake, imm_awake,
    output res_valid, res_tag, res_taken, res_target, res_mispredict
  );

endinterface

// File: rtl/bru_cond.sv
// Branch resolve datapath: direction compare, actual next PC, mispredict flag.
// Purely combinational, zero latency.
// No flow control; evaluated every cycle on whatever EX holds.
module bru_cond
  import bru_exec_pkg::*;
(
  input  logic [3:0]          op,
  input  logic [BRU_XLEN-1:0] src1,
  input  logic [BRU_XLEN-1:0] src2,
  input  logic [BRU_XLEN-1:0] pc,
  input  logic [BRU_XLEN-1:0] offs,
  input  logic [BRU_XLEN-1:0] imm,
  input  logic                pred_taken,
  input  logic [BRU_XLEN-1:0] pred_target,
  input  logic [BRU_XLEN-1:0] jirl_pred,
  output logic                taken,
  output logic [BRU_XLEN-1:0] target,
  output logic                mispredict
);

  logic [BRU_XLEN-1:0] pc_seq;
  logic [BRU_XLEN-1:0] br_target;
  logic [BRU_XLEN-1:0] jirl_target;
  logic                is_cond;
  logic                cond;

  assign pc_seq      = pc + 32'd4;
  assign br_target   = pc + offs;
  assign jirl_target = (src1 + imm) & ~32'd3;

  // Decode op into direction and next PC; illegal codes fall through as not-taken.
  always_comb begin
    is_cond    = 1'b0;
    cond       = 1'b0;
    taken      = 1'b0;
    target     = pc_seq;
    mispredict = 1'b0;
    case (op)
      BRU_BEQ:  begin is_cond = 1'b1; cond = (src1 == src2);                   end
      BRU_BNE:  begin is_cond = 1'b1; cond = (src1 != src2);                   end
      BRU_BLT:  begin is_cond = 1'b1; cond = ($signed(src1) <  $signed(src2)); end
      BRU_BGE:  begin is_cond = 1'b1; cond = ($signed(src1) >= $signed(src2)); end
      BRU_BLTU: begin is_cond = 1'b1; cond = (src1 <  src2);                   end
      BRU_BGEU: begin is_cond = 1'b1; cond = (src1 >= src2);                   end
      BRU_JIRL: begin
        taken      = 1'b1;
        target     = jirl_target;
        mispredict = (jirl_target != jirl_pred);
      end
      default: ;
    endcase
    if (is_cond) begin
      taken      = cond;
      target     = cond ? br_target : pc_seq;
      mispredict = (cond != pred_taken) || (cond && (br_target != pred_target));
    end
  end

endmodule

// File: rtl/bru_exec.sv
// Branch execution unit: RR (operand read + CDB bypass) then EX (resolve), result to ROB.
// Latency 2 cycles from issue to res_valid; one uop per cycle.
// No backpressure; uops younger than an outstanding mispredict are dropped in EX.
module bru_exec
  import bru_exec_pkg::*;
#(
  parameter int PRF_W = BRU_PRF_W,
  parameter int TAG_W = BRU_TAG_W,
  parameter int CDB_N = BRU_CDB_N
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [TAG_W-1:0]            ptr_old,
  bru_exec_if.slave                   bif,
  output logic [1:0][PRF_W-1:0]       prf_raddr,
  input  logic [1:0][31:0]            prf_rdata,
  input  logic [CDB_N-1:0]            ready_cdb,
  input  logic [CDB_N-1:0]            RegWr_cdb,
  input  logic [CDB_N-1:0][PRF_W-1:0] Pd_cdb,
  input  logic [CDB_N-1:0][31:0]      data_cdb,
  output logic [TAG_W-1:0]            pcb_rtag,
  input  logic [31:0]                 pcb_pc,
  input  logic [31:0]                 pcb_offs,
  input  logic                        pcb_pred_taken,
  input  logic [31:0]                 pcb_pred_target,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc,
  output logic [31:0]                 cnt_branch,
  output logic [31:0]                 cnt_mispred
);

  // ---------------- RR stage ----------------
  logic [1:0][31:0] opnd;
  bru_ex_t          rr_d;
  bru_ex_t          ex_q;

  assign prf_raddr[0] = bif.Pj_awake;
  assign prf_raddr[1] = bif.Pd_old_awake;
  assign pcb_rtag     = bif.tag_rob_awake;

  // Operand select: PRF by default, later CDB ports override earlier ones.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      opnd[k] = prf_rdata[k];
      for (int i = 0; i < CDB_N; i++) begin
        if (ready_cdb[i] && RegWr_cdb[i] && (Pd_cdb[i] == prf_raddr[k]))
          opnd[k] = data_cdb[i];
      end
    end
  end

  // Assemble the EX bundle; a uop arriving alongside flush is discarded here.
  always_comb begin
    rr_d             = '0;
    rr_d.valid       = bif.ready_awake && !flush;
    rr_d.tag         = bif.tag_rob_awake;
    rr_d.op          = bif.Conf_awake;
    rr_d.src1        = opnd[0];
    rr_d.src2        = opnd[1];
    rr_d.pc          = pcb_pc;
    rr_d.offs        = pcb_offs;
    rr_d.pred_taken  = pcb_pred_taken;
    rr_d.pred_target = pcb_pred_target;
    rr_d.jirl_pred   = bif.target_predict_awake;
    rr_d.imm         = bif.imm_awake;
  end

  // RR -> EX pipeline register.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= rr_d;
  end

  // ---------------- EX stage ----------------
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;

  bru_cond u_cond (
    .op          (ex_q.op),
    .src1        (ex_q.src1),
    .src2        (ex_q.src2),
    .pc          (ex_q.pc),
    .offs        (ex_q.offs),
    .imm         (ex_q.imm),
    .pred_taken  (ex_q.pred_taken),
    .pred_target (ex_q.pred_target),
    .jirl_pred   (ex_q.jirl_pred),
    .taken       (ex_taken),
    .target      (ex_target),
    .mispredict  (ex_mispredict)
  );

  // ---------------- shadow FSM ----------------
  bru_state_e       state_q, state_d;
  logic [TAG_W-1:0] shadow_tag_q, shadow_tag_d;
  logic             redir_vld_d;
  logic [31:0]      redir_pc_d;
  logic             emit;
  logic             ex_older;

  assign ex_older = age_older(ex_q.tag, shadow_tag_q, ptr_old);

  // Decide whether the EX uop is emitted and how the outstanding redirect evolves.
  always_comb begin
    state_d      = state_q;
    shadow_tag_d = shadow_tag_q;
    redir_vld_d  = redirect_valid;
    redir_pc_d   = redirect_pc;
    emit         = 1'b0;
    if (flush) begin
      state_d     = ST_NORMAL;
      redir_vld_d = 1'b0;
    end else begin
      case (state_q)
        ST_NORMAL: emit = ex_q.valid;
        ST_SHADOW: emit = ex_q.valid && ex_older;
        default:   emit = 1'b0;
      endcase
      // Any emitted mispredict is older than whatever redirect is outstanding.
      if (emit && ex_mispredict) begin
        state_d      = ST_SHADOW;
        shadow_tag_d = ex_q.tag;
        redir_vld_d  = 1'b1;
        redir_pc_d   = ex_target;
      end
    end
  end

  // FSM state, shadow tag and redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_NORMAL;
      shadow_tag_q   <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      shadow_tag_q   <= shadow_tag_d;
      redirect_valid <= redir_vld_d;
      redirect_pc    <= redir_pc_d;
    end
  end

  // ---------------- result + counters ----------------
  logic        res_valid_q;
  logic [TAG_W-1:0] res_tag_q;
  logic        res_taken_q;
  logic [31:0] res_target_q;
  logic        res_mispredict_q;

  // Resolution register; payload is qualified by res_valid, mispredict only when emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q      <= 1'b0;
      res_tag_q        <= '0;
      res_taken_q      <= 1'b0;
      res_target_q     <= '0;
      res_mispredict_q <= 1'b0;
    end else begin
      res_valid_q      <= emit;
      res_tag_q        <= ex_q.tag;
      res_taken_q      <= ex_taken;
      res_target_q     <= ex_target;
      res_mispredict_q <= emit && ex_mispredict;
    end
  end

  // Saturating event counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else begin
      if (emit && (cnt_branch != '1))
        cnt_branch <= cnt_branch + 32'd1;
      if (emit && ex_mispredict && (cnt_mispred != '1))
        cnt_mispred <= cnt_mispred + 32'd1;
    end
  end

  assign bif.res_valid      = res_valid_q;
  assign bif.res_tag        = res_tag_q;
  assign bif.res_taken      = res_taken_q;
  assign bif.res_target     = res_target_q;
  assign bif.res_mispredict = res_mispredict_q;

endmodule

// File: tb/tb_bru_exec.sv
// Directed bench for bru_exec: hand-computed vectors, counters tracked alongside.
// Issue at cycle t, results sampled 1 time unit after the t+2 edge.
// No backpressure to exercise; bench drives at most one uop per cycle.
module tb_bru_exec;
  import bru_exec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             flush;
  logic [5:0]       ptr_old;
  logic [1:0][5:0]  prf_raddr;
  logic [1:0][31:0] prf_rdata;
  logic [4:0]       ready_cdb;
  logic [4:0]       RegWr_cdb;
  logic [4:0][5:0]  Pd_cdb;
  logic [4:0][31:0] data_cdb;
  logic [5:0]       pcb_rtag;
  logic [31:0]      pcb_pc;
  logic [31:0]      pcb_offs;
  logic             pcb_pred_taken;
  logic [31:0]      pcb_pred_target;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      cnt_branch;
  logic [31:0]      cnt_mispred;

  bru_exec_if bif ();

  bru_exec u_dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .ptr_old         (ptr_old),
    .bif             (bif),
    .prf_raddr       (prf_raddr),
    .prf_rdata       (prf_rdata),
    .ready_cdb       (ready_cdb),
    .RegWr_cdb       (RegWr_cdb),
    .Pd_cdb          (Pd_cdb),
    .data_cdb        (data_cdb),
    .pcb_rtag        (pcb_rtag),
    .pcb_pc          (pcb_pc),
    .pcb_offs        (pcb_offs),
    .pcb_pred_taken  (pcb_pred_taken),
    .pcb_pred_target (pcb_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .cnt_branch      (cnt_branch),
    .cnt_mispred     (cnt_mispred)
  );

  int total = 0;
  int bad   = 0;
  int exp_br = 0;
  int exp_mp = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uop(input logic [3:0] op, input logic [5:0] tag,
                           input logic [31:0] rj, input logic [31:0] rd,
                           input logic [31:0] pc, input logic [31:0] offs,
                           input logic pt, input logic [31:0] ptgt,
                           input logic [31:0] jtp, input logic [31:0] imm);
    bif.ready_awake          = 1'b1;
    bif.Conf_awake           = op;
    bif.tag_rob_awake        = tag;
    bif.Pj_awake             = 6'd3;
    bif.Pd_old_awake         = 6'd4;
    bif.target_predict_awake = jtp;
    bif.imm_awake            = imm;
    prf_rdata[0]             = rj;
    prf_rdata[1]             = rd;
    pcb_pc                   = pc;
    pcb_offs                 = offs;
    pcb_pred_taken           = pt;
    pcb_pred_target          = ptgt;
  endtask

  // Issue one uop, then advance so its resolution is visible.
  task automatic run_uop(input logic [3:0] op, input logic [5:0] tag,
                         input logic [31:0] rj, input logic [31:0] rd,
                         input logic [31:0] pc, input logic [31:0] offs,
                         input logic pt, input logic [31:0] ptgt,
                         input logic [31:0] jtp, input logic [31:0] imm);
    drive_uop(op, tag, rj, rd, pc, offs, pt, ptgt, jtp, imm);
    step();
    bif.ready_awake = 1'b0;
    step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_redirect_clr", {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ptr_old = 6'd0;
    bif.ready_awake = 1'b0; bif.Conf_awake = 4'd0; bif.tag_rob_awake = 6'd0;
    bif.Pj_awake = 6'd0; bif.Pd_old_awake = 6'd0;
    bif.target_predict_awake = 32'd0; bif.imm_awake = 32'd0;
    prf_rdata = '0; ready_cdb = '0; RegWr_cdb = '0; Pd_cdb = '0; data_cdb = '0;
    pcb_pc = 32'd0; pcb_offs = 32'd0; pcb_pred_taken = 1'b0; pcb_pred_target = 32'd0;
    step(); step();
    rst = 1'b0;

    chk("rst_res_valid", {31'd0, bif.res_valid}, 32'd0);
    chk("rst_redirect",  {31'd0, redirect_valid}, 32'd0);
    chk("rst_cnt_br",    cnt_branch, 32'd0);
    chk("rst_cnt_mp",    cnt_mispred, 32'd0);

    // BEQ taken, correctly predicted
    run_uop(BRU_BEQ, 6'd1, 32'd5, 32'd5, 32'h1000, 32'h40, 1'b1, 32'h1040, 32'd0, 32'd0);
    exp_br++;
    chk("beq_valid",  {31'd0, bif.res_valid}, 32'd1);
    chk("beq_tag",    {26'd0, bif.res_tag}, 32'd1);
    chk("beq_taken",  {31'd0, bif.res_taken}, 32'd1);
    chk("beq_target", bif.res_target, 32'h1040);
    chk("beq_mis",    {31'd0, bif.res_mispredict}, 32'd0);
    chk("beq_cnt_br", cnt_branch, exp_br);
    step();
    chk("beq_pulse_end", {31'd0, bif.res_valid}, 32'd0);

    // BLTU: 0xFFFFFFFF is not below 1 unsigned; predicted taken -> mispredict
    run_uop(BRU_BLTU, 6'd2, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h40, 1'b1, 32'h2040, 32'd0, 32'd0);
    exp_br++; exp_mp++;
    chk("bltu_taken",  {31'd0, bif.res_taken}, 32'd0);
    chk("bltu_target", bif.res_target, 32'h2004);
    chk("bltu_mis",    {31'd0, bif.res_mispredict}, 32'd1);
    chk("bltu_redir",  {31'd0, redirect_valid}, 32'd1);
    chk("bltu_redir_pc", redirect_pc, 32'h2004);
    chk("bltu_cnt_mp", cnt_mispred, exp_mp);
    chk("bltu_cnt_br", cnt_branch, exp_br);
    do_flush();

    // JIRL: (0x2003 + 0x10) & ~3 = 0x2010
    run_uop(BRU_JIRL, 6'd3, 32'h2003, 32'd0, 32'h3000, 32'd0, 1'b0, 32'd0, 32'h2010, 32'h10);
    exp_br++;
    chk("jirl_taken",  {31'd0, bif.res_taken}, 32'd1);
    chk("jirl_target", bif.res_target, 32'h2010);
    chk("jirl_mis",    {31'd0, bif.res_mispredict}, 32'd0);
    run_uop(BRU_JIRL, 6'd4, 32'h2003, 32'd0, 32'h3000, 32'd0, 1'b0, 32'd0, 32'h3000, 32'h10);
    exp_br++; exp_mp++;
    chk("jirl2_mis",   {31'd0, bif.res_mispredict}, 32'd1);
    chk("jirl2_redir_pc", redirect_pc, 32'h2010);
    do_flush();

    // Bypass: port 1 and port 3 both match Pj=7, highest port (data 9) wins
    drive_uop(BRU_BEQ, 6'd5, 32'd0, 32'd9, 32'h4000, 32'h20, 1'b1, 32'h4020, 32'd0, 32'd0);
    bif.Pj_awake = 6'd7; bif.Pd_old_awake = 6'd8;
    ready_cdb = 5'b01010; RegWr_cdb = 5'b01010;
    Pd_cdb[1] = 6'd7; data_cdb[1] = 32'd5;
    Pd_cdb[3] = 6'd7; data_cdb[3] = 32'd9;
    #1;
    chk("raddr_pj", {26'd0, prf_raddr[0]}, 32'd7);
    chk("raddr_pd", {26'd0, prf_raddr[1]}, 32'd8);
    chk("pcb_rtag", {26'd0, pcb_rtag}, 32'd5);
    step();
    bif.ready_awake = 1'b0; ready_cdb = '0; RegWr_cdb = '0;
    step();
    exp_br++;
    chk("byp_taken", {31'd0, bif.res_taken}, 32'd1);
    chk("byp_target", bif.res_target, 32'h4020);
    chk("byp_mis",   {31'd0, bif.res_mispredict}, 32'd0);

    // BLT signed: -1 < 1 taken, negative offset wraps
    run_uop(BRU_BLT, 6'd6, 32'hFFFF_FFFF, 32'd1, 32'h5000, 32'hFFFF_FFF0, 1'b1, 32'h4FF0, 32'd0, 32'd0);
    exp_br++;
    chk("blt_taken",  {31'd0, bif.res_taken}, 32'd1);
    chk("blt_target", bif.res_target, 32'h4FF0);
    chk("blt_mis",    {31'd0, bif.res_mispredict}, 32'd0);

    // Illegal op 6: not taken, no mispredict even though predicted taken
    run_uop(4'd6, 6'd7, 32'd1, 32'd1, 32'h9000, 32'h80, 1'b1, 32'h9080, 32'd0, 32'd0);
    exp_br++;
    chk("ill_valid",  {31'd0, bif.res_valid}, 32'd1);
    chk("ill_taken",  {31'd0, bif.res_taken}, 32'd0);
    chk("ill_target", bif.res_target, 32'h9004);
    chk("ill_mis",    {31'd0, bif.res_mispredict}, 32'd0);
    chk("ill_cnt_mp", cnt_mispred, exp_mp);

    // Shadow, ptr_old = 60
    ptr_old = 6'd60;
    run_uop(BRU_BNE, 6'd62, 32'd3, 32'd3, 32'h6000, 32'h10, 1'b1, 32'h6010, 32'd0, 32'd0);
    exp_br++; exp_mp++;
    chk("sh62_redir_pc", redirect_pc, 32'h6004);
    run_uop(BRU_BEQ, 6'd63, 32'd1, 32'd1, 32'h6100, 32'h10, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("sh63_dropped", {31'd0, bif.res_valid}, 32'd0);
    chk("sh63_cnt_br",  cnt_branch, exp_br);
    run_uop(BRU_BEQ, 6'd61, 32'd2, 32'd2, 32'h7000, 32'h100, 1'b0, 32'd0, 32'd0, 32'd0);
    exp_br++; exp_mp++;
    chk("sh61_valid",    {31'd0, bif.res_valid}, 32'd1);
    chk("sh61_tag",      {26'd0, bif.res_tag}, 32'd61);
    chk("sh61_redir_pc", redirect_pc, 32'h7100);
    chk("sh61_cnt_mp",   cnt_mispred, exp_mp);
    run_uop(BRU_BEQ, 6'd62, 32'd1, 32'd1, 32'h6200, 32'h10, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("sh62b_dropped", {31'd0, bif.res_valid}, 32'd0);
    do_flush();
    run_uop(BRU_BEQ, 6'd63, 32'd1, 32'd1, 32'h8000, 32'h8, 1'b1, 32'h8008, 32'd0, 32'd0);
    exp_br++;
    chk("post_flush_emit", {31'd0, bif.res_valid}, 32'd1);
    chk("post_flush_cnt",  cnt_branch, exp_br);

    // Uop presented together with flush is discarded
    drive_uop(BRU_BEQ, 6'd0, 32'd1, 32'd1, 32'hA000, 32'h8, 1'b1, 32'hA008, 32'd0, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; bif.ready_awake = 1'b0;
    step();
    chk("flush_same_cyc", {31'd0, bif.res_valid}, 32'd0);
    chk("flush_keeps_cnt", cnt_branch, exp_br);

    // Reset mid-flight while in SHADOW with uops in RR and EX
    run_uop(BRU_BNE, 6'd5, 32'd1, 32'd1, 32'hB000, 32'h8, 1'b1, 32'hB008, 32'd0, 32'd0);
    chk("pre_rst_redir", {31'd0, redirect_valid}, 32'd1);
    drive_uop(BRU_BEQ, 6'd2, 32'd1, 32'd1, 32'hC000, 32'h8, 1'b1, 32'hC008, 32'd0, 32'd0);
    step();
    drive_uop(BRU_BEQ, 6'd3, 32'd1, 32'd1, 32'hC100, 32'h8, 1'b1, 32'hC108, 32'd0, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; bif.ready_awake = 1'b0;
    chk("rst_mid_res0", {31'd0, bif.res_valid}, 32'd0);
    step();
    chk("rst_mid_res1", {31'd0, bif.res_valid}, 32'd0);
    chk("rst_mid_redir", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mid_cnt_br", cnt_branch, 32'd0);
    chk("rst_mid_cnt_mp", cnt_mispred, 32'd0);
    // Tag 20 is younger than the pre-reset shadow tag 5; emission shows FSM is NORMAL
    run_uop(BRU_BEQ, 6'd20, 32'd1, 32'd1, 32'hD000, 32'h8, 1'b1, 32'hD008, 32'd0, 32'd0);
    chk("rst_normal_emit", {31'd0, bif.res_valid}, 32'd1);
    chk("rst_normal_cnt",  cnt_branch, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bru_exec.md
Name: bru_exec

Overview:
- Branch execution unit fed directly by the branch issue queue's single awake port. Reads the two physical source operands and fetches the branch's PC and prediction metadata by ROB tag.
- Resolves direction and target in a 2-stage pipeline (RR, EX) and reports the resolution to the ROB.
- Tracks a mispredict shadow so that younger in-flight branches cannot overwrite an older redirect.

Parameters:
- PRF_W, 6, physical register index width
- TAG_W, 6, ROB tag width (64-entry ROB)
- CDB_N, 5, number of CDB broadcast ports

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high. One clock.
- flush  in  1  pipeline flush from ROB
- ptr_old  in  6  ROB head tag, used as the age base
- ready_awake  in  1  issued uop valid
- Pj_awake  in  6  source rj
- Pd_old_awake  in  6  source rd (compare operand)
- Conf_awake  in  4  op code: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 8 JIRL; others are illegal
- tag_rob_awake  in  6  ROB tag
- target_predict_awake  in  32  JIRL predicted target
- imm_awake  in  32  JIRL offset, already sign-extended and shifted
- prf_raddr  out  6x2  combinational PRF read addresses (Pj, Pd_old)
- prf_rdata  in  32x2  same-cycle read data
- ready_cdb, RegWr_cdb  in  1xCDB_N  CDB valid / write flags
- Pd_cdb  in  6xCDB_N  CDB destination tags
- data_cdb  in  32xCDB_N  CDB data
- pcb_rtag  out  6  combinational PC-buffer read tag
- pcb_pc  in  32  branch PC
- pcb_offs  in  32  conditional-branch offset, sign-extended and shifted
- pcb_pred_taken  in  1  predicted direction
- pcb_pred_target  in  32  predicted target
- res_valid  out  1  resolution pulse to ROB
- res_tag  out  6  resolved tag
- res_taken  out  1  actual direction
- res_target  out  32  actual next PC
- res_mispredict  out  1  prediction wrong
- redirect_valid  out  1  level: a mispredict is outstanding
- redirect_pc  out  32  correct next PC for the outstanding mispredict
- cnt_branch  out  32  resolved branches counter
- cnt_mispred  out  32  mispredicts counter

Behaviour:
- Reset (rst=1 at posedge):
  - all stage valids, res_* and redirect_* go to 0
  - counters go to 0
  - FSM goes to NORMAL
- RR stage (cycle t, ready_awake=1):
  - prf_raddr and pcb_rtag are driven from the awake inputs.
  - Operand bypass: the highest-numbered CDB port i with ready&RegWr&Pd_cdb[i]==addr supplies data_cdb[i]; otherwise prf_rdata is used.
  - Operands, PC-buffer data and control are registered into EX at the t+1 edge.
- EX stage (cycle t+1):
  - Conditional branches:
    - cond is eq, ne, signed lt/ge or unsigned lt/ge of rj vs rd.
    - target = pc + offs when taken, else pc+4.
    - mispredict = (taken != pred_taken) || (taken && target != pred_target).
  - JIRL: always taken; target = (rj + imm) & ~3; mispredict = target != target_predict.
  - Illegal Conf: resolve as not-taken, no mispredict.
  - All adds are 32-bit wraparound.
  - res_* are registered and visible in cycle t+2 for exactly one cycle. Total latency is 2 cycles.
  - Throughput is one uop/cycle, with no backpressure.
- Age: age(x) = (x - ptr_old) mod 64. Smaller age is older.
- FSM states:
  - NORMAL:
    - every EX result is emitted
    - a mispredict sets redirect_valid=1, redirect_pc=res_target and shadow_age_tag=tag, then moves to SHADOW
  - SHADOW:
    - EX uop with age >= age(shadow tag) is dropped: no res_valid, no counter change
    - an older uop is emitted normally
    - if that older uop mispredicts, it replaces redirect_pc and the shadow tag and the FSM stays in SHADOW
  - SHADOW -> NORMAL only on flush.
- flush:
  - next edge clears RR/EX valids, res_valid, redirect_valid and FSM
  - a uop presented in the same cycle as flush is discarded
  - flush and rst together behave as rst
  - counters are not cleared by flush
- Counters:
  - cnt_branch increments once per emitted res_valid
  - cnt_mispred increments once per emitted res_mispredict
  - both saturate at all-ones

Decomposition:
- Shared package entries:
  - BRU op encodings (BRU_BEQ..BRU_JIRL)
  - age-compare function
  - the EX-stage pipeline struct (valid, tag, op, src1, src2, pc, offs, pred_taken, pred_target, jirl_pred, imm)
- Sub-module bru_cond: purely combinational compare/target/mispredict logic, instantiated once in EX.

Test Plan:
- BEQ, rj=rd=5, pc=0x1000, offs=0x40, pred_taken=1, pred_target=0x1040 -> at t+2: res_valid=1, taken=1, target=0x1040, mispredict=0, cnt_branch=1.
- BLTU, rj=0xFFFFFFFF, rd=1, pred_taken=1 -> taken=0, target=pc+4, mispredict=1, redirect_valid=1, redirect_pc=pc+4, cnt_mispred=1.
- JIRL, rj=0x2003, imm=0x10, target_predict=0x2010 -> target=0x2010, mispredict=0. Same case with target_predict=0x3000 -> mispredict=1.
- Bypass: issue BEQ with Pj=7 while CDB port 3 broadcasts Pd=7, data=9 and PRF returns 0, rd=9 -> taken=1.
- Shadow, ptr_old=60:
  - tag 62 mispredicts, then tag 63 issues -> tag 63 dropped (no res_valid).
  - then tag 61 mispredicts -> emitted and redirect_pc updated.
  - flush -> redirect_valid=0 next cycle.
- Reset mid-flight with uops in RR and EX -> no res_valid after reset, counters 0, FSM NORMAL.
